// File: rtl/bus_master_pkg.sv
// bus_master_pkg: shared state encoding, direction codes and header layout
package bus_master_pkg;
  typedef enum logic [2:0] {
    IDLE, WR_ISSUE, WR_REQ, WR_BURST, RD_ISSUE, RD_REQ, RD_BURST, WAIT
  } state_t;
  localparam logic DIR_WR = 1'b0;
  localparam logic DIR_RD = 1'b1;
  localparam int HDR_CH_LSB = 0;
  function automatic int hdr_dir_bit(input int ch_w);
    return HDR_CH_LSB + ch_w;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after last_grant
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] last_grant,
  input  logic          enable,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);
  logic [IW-1:0] j;
  // walk candidates farthest-first so the nearest eligible one after last_grant wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx = '0;
    j = '0;
    for (int i = N; i >= 1; i--) begin
      j = IW'((int'(last_grant) + i) % N);
      if (enable && eligible[j]) begin
        grant_valid = 1'b1;
        grant_idx = j;
      end
    end
  end
endmodule

// File: rtl/bus_master_rr.sv
// bus_master_rr: round-robin multi-channel bus master with burst cap and abort
module bus_master_rr
  import bus_master_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 256,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     ack_i,
  input  logic                     abort_i,
  input  logic                     s_rdy_i,
  output logic                     m_rdy_o,
  output logic                     we_o,
  output logic                     stb_o,
  input  logic [DATA_W-1:0]        dat_i,
  output logic [DATA_W-1:0]        dat_o,
  output logic                     dat_o_enable_o,
  input  logic [NUM_CH-1:0]        req_w_i,
  input  logic [NUM_CH-1:0]        req_r_i,
  output logic [NUM_CH-1:0]        r_fifo_rd_o,
  input  logic [NUM_CH*DATA_W-1:0] r_fifo_dat_i,
  input  logic [NUM_CH-1:0]        r_fifo_empty_i,
  output logic [DATA_W-1:0]        w_fifo_dat_o,
  output logic [NUM_CH-1:0]        w_fifo_dat_valid_o,
  input  logic [NUM_CH-1:0]        w_fifo_prog_full_i,
  output logic                     busy_o,
  output logic [CH_W-1:0]          cur_ch_o
);
  localparam int K = 2 * NUM_CH;
  localparam int KW = $clog2(K);
  localparam int HDR_DIR = hdr_dir_bit(CH_W);
  state_t state;
  logic [CH_W-1:0] cur_ch;
  logic cur_dir;
  logic [CNT_W-1:0] count;
  logic [KW-1:0] last_grant, grant_idx;
  logic [K-1:0] eligible;
  logic grant_valid, cur_empty, cur_pf, cap, pop, push;
  logic [DATA_W-1:0] header;
  // requestor k = 2*c + dir: writes need read-FIFO data, reads need write-FIFO room
  always_comb begin
    eligible = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      eligible[2*c]   = req_w_i[c] & ~r_fifo_empty_i[c];
      eligible[2*c+1] = req_r_i[c] & ~w_fifo_prog_full_i[c];
    end
  end
  rr_arbiter #(.N(K), .IW(KW)) u_arb (
    .eligible   (eligible),
    .last_grant (last_grant),
    .enable     (state == IDLE),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );
  assign cur_empty = r_fifo_empty_i[cur_ch];
  assign cur_pf = w_fifo_prog_full_i[cur_ch];
  assign cap = count == CNT_W'(MAX_BURST);
  assign pop = (state == WR_REQ || state == WR_BURST) && ack_i && !abort_i && !cur_empty && !cap;
  assign push = state == RD_BURST && s_rdy_i && ack_i && !cap;
  assign r_fifo_rd_o = NUM_CH'(pop) << cur_ch;
  assign we_o = state inside {WR_ISSUE, WR_REQ, WR_BURST};
  assign stb_o = !(state inside {IDLE, WAIT});
  assign m_rdy_o = state == WR_BURST;
  assign dat_o_enable_o = state inside {WR_ISSUE, RD_ISSUE, WR_BURST};
  assign busy_o = state != IDLE;
  assign cur_ch_o = cur_ch;
  // header word identifies the granted channel and direction
  always_comb begin
    header = '0;
    header[HDR_CH_LSB +: CH_W] = cur_ch;
    header[HDR_DIR] = cur_dir;
  end
  assign dat_o = m_rdy_o ? r_fifo_dat_i[cur_ch*DATA_W +: DATA_W] : header;
  // transaction FSM, grant bookkeeping and saturating word counter
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      cur_ch <= '0;
      cur_dir <= DIR_WR;
      count <= '0;
      last_grant <= KW'(K - 1);
    end else begin
      if (pop || push) count <= count + 1'b1;
      case (state)
        IDLE: if (grant_valid) begin
          state <= (grant_idx[0] == DIR_RD) ? RD_ISSUE : WR_ISSUE;
          cur_ch <= CH_W'(grant_idx >> 1);
          cur_dir <= grant_idx[0];
          last_grant <= grant_idx;
          count <= '0;
        end
        WR_ISSUE: state <= WR_REQ;
        RD_ISSUE: state <= RD_REQ;
        WR_REQ: state <= abort_i ? IDLE : !ack_i ? WR_REQ : cur_empty ? WAIT : WR_BURST;
        RD_REQ: state <= abort_i ? IDLE : !ack_i ? RD_REQ : cur_pf ? WAIT : RD_BURST;
        WR_BURST: state <= (!ack_i || abort_i) ? IDLE : (cur_empty || cap) ? WAIT : WR_BURST;
        RD_BURST: state <= (!ack_i || abort_i) ? IDLE : (cur_pf || cap) ? WAIT : RD_BURST;
        WAIT: state <= ack_i ? WAIT : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // write-FIFO data follows dat_i every cycle; push strobe only for the granted channel
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_fifo_dat_o <= '0;
      w_fifo_dat_valid_o <= '0;
    end else begin
      w_fifo_dat_o <= dat_i;
      w_fifo_dat_valid_o <= NUM_CH'(push) << cur_ch;
    end
  end
endmodule

// File: tb/tb_bus_master_rr.sv
// tb_bus_master_rr: directed checks of arbitration, bursts, abort and reset
module tb_bus_master_rr;
  logic clk = 1'b0;
  logic reset_n, ack, abort, s_rdy, m_rdy, we, stb, en, busy, cur_ch;
  logic [31:0] dat_i, dat_o, w_dat;
  logic [1:0] req_w, req_r, r_rd, r_empty, w_val, w_pf;
  logic [63:0] r_dat;
  logic b_m_rdy, b_we, b_stb, b_en, b_busy;
  logic [31:0] b_dat_o, b_w_dat;
  logic [3:0] b_req_r, b_r_rd, b_w_val;
  logic [1:0] b_cur_ch;
  logic found;
  int checks = 0;
  int errors = 0;
  int rp [2] = '{0, 0};
  logic [31:0] rdat [2];
  logic [31:0] seen [$];
  bit rdy_pat [7] = '{1, 0, 1, 1, 0, 1, 1};
  bit val_exp [7] = '{1, 0, 1, 1, 0, 1, 0};
  logic [31:0] exp_d;
  int n;

  always #5 clk = ~clk;

  bus_master_rr #(.NUM_CH(2), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .ack_i(ack), .abort_i(abort), .s_rdy_i(s_rdy),
    .m_rdy_o(m_rdy), .we_o(we), .stb_o(stb), .dat_i(dat_i), .dat_o(dat_o),
    .dat_o_enable_o(en), .req_w_i(req_w), .req_r_i(req_r), .r_fifo_rd_o(r_rd),
    .r_fifo_dat_i(r_dat), .r_fifo_empty_i(r_empty), .w_fifo_dat_o(w_dat),
    .w_fifo_dat_valid_o(w_val), .w_fifo_prog_full_i(w_pf), .busy_o(busy), .cur_ch_o(cur_ch)
  );

  bus_master_rr #(.NUM_CH(4), .DATA_W(32), .MAX_BURST(4)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .ack_i(1'b0), .abort_i(1'b0), .s_rdy_i(1'b0),
    .m_rdy_o(b_m_rdy), .we_o(b_we), .stb_o(b_stb), .dat_i(32'h0), .dat_o(b_dat_o),
    .dat_o_enable_o(b_en), .req_w_i(4'h0), .req_r_i(b_req_r), .r_fifo_rd_o(b_r_rd),
    .r_fifo_dat_i(128'h0), .r_fifo_empty_i(4'hF), .w_fifo_dat_o(b_w_dat),
    .w_fifo_dat_valid_o(b_w_val), .w_fifo_prog_full_i(4'h0), .busy_o(b_busy), .cur_ch_o(b_cur_ch)
  );

  // read FIFOs: ch0 holds 10 words, ch1 holds 4; popped word appears the cycle after the pop
  assign r_dat = {rdat[1], rdat[0]};
  assign r_empty = {rp[1] >= 4, rp[0] >= 10};
  always @(posedge clk)
    for (int c = 0; c < 2; c++)
      if (r_rd[c]) begin
        rdat[c] <= (c == 0 ? 32'h1000_0000 : 32'h2000_0000) + 32'(rp[c]);
        rp[c] <= rp[c] + 1;
      end

  always @(negedge clk) begin
    #1;
    if (m_rdy) seen.push_back(dat_o);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // mode 0: issue cycle, 1: write burst, 2: WAIT, 3: idle
  task automatic wait_for(input string tag, input int mode);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      #1;
      found = mode == 0 ? (stb && en && !m_rdy) : mode == 1 ? m_rdy :
              mode == 2 ? (busy && !stb) : !busy;
    end
    chk(tag, found, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset_n = 0; ack = 0; abort = 0; s_rdy = 0; dat_i = 0;
    req_w = 0; req_r = 0; w_pf = 0; b_req_r = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stb", stb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur_ch", cur_ch, 0);
    chk("rst_wval", w_val, 0);
    chk("rst_wdat", w_dat, 0);
    chk("rst_rd", r_rd, 0);
    chk("rst_dat_o", dat_o, 0);
    chk("rst_en", en, 0);
    @(negedge clk);
    reset_n = 1;
    b_req_r = 4'b0010;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      #1;
      found = b_stb && b_en;
    end
    chk("hdr4_seen", found, 1);
    chk("hdr4_dat", b_dat_o, 32'h5);
    chk("hdr4_ch", b_cur_ch, 1);
    chk("hdr4_we", b_we, 0);
    b_req_r = 0;
    // all four requestors eligible, abort closes each transaction in its REQ state
    req_w = 2'b11; req_r = 2'b11; abort = 1;
    for (int k = 0; k < 5; k++) begin
      wait_for("rr_issue", 0);
      chk("rr_k", 2 * int'(cur_ch) + (we ? 0 : 1), k % 4);
    end
    req_w = 0; req_r = 0;
    wait_for("rr_idle", 3);
    abort = 0;
    chk("rr_no_pop", rp[0] + rp[1], 0);
    chk("rr_no_push", w_val, 0);
    // capped write burst on ch0
    seen.delete();
    ack = 1; req_w = 2'b01;
    wait_for("burst_wait", 2);
    chk("burst_pops", rp[0], 4);
    for (int i = 0; i < 4; i++) chk("burst_dat", seen.size() > i ? seen[i] : 32'hx, 32'h1000_0000 + i);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("wait_hold_stb", stb, 0);
      chk("wait_hold_busy", busy, 1);
      chk("wait_hold_rd", r_rd, 0);
    end
    ack = 0;
    wait_for("wait_exit", 3);
    ack = 1;
    wait_for("resume_burst", 1);
    chk("resume_dat", dat_o, 32'h1000_0004);
    req_w = 0;
    wait_for("resume_wait", 2);
    chk("resume_pops", rp[0], 8);
    ack = 0;
    wait_for("resume_idle", 3);
    // read burst on ch1 with a pulsed s_rdy; fourth push hits the cap
    req_r = 2'b10; ack = 1;
    wait_for("rd_issue", 0);
    chk("rd_ch", cur_ch, 1);
    chk("rd_we", we, 0);
    chk("hdr2_dat", dat_o, 32'h3);
    req_r = 0;
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      s_rdy = rdy_pat[i];
      dat_i = rdy_pat[i] ? 32'hA5A5_0001 + n : 32'hDEAD_0000 + i;
      exp_d = dat_i;
      if (rdy_pat[i]) n++;
      @(posedge clk);
      #1;
      chk("rd_wval", w_val, val_exp[i] ? 2'b10 : 2'b00);
      chk("rd_wdat", w_dat, exp_d);
    end
    s_rdy = 0;
    @(negedge clk);
    #1;
    chk("rd_wait_stb", stb, 0);
    chk("rd_wait_busy", busy, 1);
    ack = 0;
    wait_for("rd_idle", 3);
    // abort in RD_REQ
    req_r = 2'b01;
    wait_for("ab_rd_issue", 0);
    @(negedge clk);
    abort = 1; s_rdy = 1; req_r = 0;
    @(negedge clk);
    #1;
    chk("ab_rd_idle", busy, 0);
    chk("ab_rd_nopush", w_val, 0);
    abort = 0; s_rdy = 0;
    // abort in WR_BURST on ch1
    req_w = 2'b10; ack = 1;
    wait_for("ab_wr_issue", 0);
    chk("ab_wr_ch", cur_ch, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ab_wr_burst", m_rdy, 1);
    abort = 1; req_w = 0;
    #1;
    chk("ab_wr_nopop", r_rd, 0);
    @(negedge clk);
    #1;
    chk("ab_wr_idle", busy, 0);
    chk("ab_wr_pops", rp[1], 1);
    abort = 0; ack = 0;
    // reset while ch1 streams
    req_w = 2'b10; ack = 1;
    wait_for("rst_issue", 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_burst", m_rdy, 1);
    reset_n = 0;
    #1;
    chk("rst_mid_stb", stb, 0);
    chk("rst_mid_rd", r_rd, 0);
    ack = 0; req_w = 2'b11; abort = 1;
    repeat (2) @(negedge clk);
    chk("rst_mid_pops", rp[1], 2);
    reset_n = 1;
    wait_for("post_rst_issue", 0);
    chk("post_rst_ch", cur_ch, 0);
    chk("post_rst_we", we, 1);
    req_w = 0;
    wait_for("post_rst_idle", 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_master_rr.md
Name: bus_master_rr

Overview:
- Parametrised successor of the two-channel bus master.
- Moves data between NUM_CH channel FIFO pairs and the shared strobe/ack backplane bus.
- Bus write: drains channel read-FIFO onto the bus. Bus read: fills channel write-FIFO from the bus.
- New over the previous generation: true round-robin arbitration across 2*NUM_CH requestors, a MAX_BURST word cap per transaction, abort honoured in burst states, and channel-qualified write-FIFO valid.

Parameters:
- NUM_CH, 2, number of channels (1..8).
- DATA_W, 32, bus and FIFO data width.
- MAX_BURST, 256, maximum words per transaction (>=1).
- CH_W, $clog2(NUM_CH) (minimum 1), channel index width.
- CNT_W, $clog2(MAX_BURST+1), burst counter width.

Ports:
- clk_i  in  1  system clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- ack_i  in  1  slave acknowledge, held for the whole transaction.
- abort_i  in  1  slave abort.
- s_rdy_i  in  1  slave data valid on dat_i (bus read).
- m_rdy_o  out  1  master data valid on dat_o (write burst).
- we_o  out  1  1 = bus write, 0 = bus read.
- stb_o  out  1  transaction strobe.
- dat_i  in  DATA_W  bus read data.
- dat_o  out  DATA_W  header or write data.
- dat_o_enable_o  out  1  dat_o drive enable.
- req_w_i  in  NUM_CH  per-channel write request.
- req_r_i  in  NUM_CH  per-channel read request.
- r_fifo_rd_o  out  NUM_CH  read-FIFO pop.
- r_fifo_dat_i  in  NUM_CH*DATA_W  read-FIFO data; channel c occupies bits [c*DATA_W +: DATA_W].
- r_fifo_empty_i  in  NUM_CH  read-FIFO empty.
- w_fifo_dat_o  out  DATA_W  registered write-FIFO data, shared by all channels.
- w_fifo_dat_valid_o  out  NUM_CH  write-FIFO push.
- w_fifo_prog_full_i  in  NUM_CH  write-FIFO programmable-full.
- busy_o  out  1  state != IDLE.
- cur_ch_o  out  CH_W  channel currently granted.

Behaviour:
- Reset (asynchronous, reset_n_i=0):
  - state=IDLE, cur_ch=0, cur_dir=0, count=0, last_grant=2*NUM_CH-1.
  - w_fifo_dat_o=0, w_fifo_dat_valid_o=0.
  - All decoded outputs 0.
  - Reset asserted mid-transaction drops stb_o immediately. No FIFO pops or pushes occur after reset assertion.
- Requestor index k = 2*c + dir (dir 0 = write, 1 = read).
  - Write requestor eligible: req_w_i[c] & ~r_fifo_empty_i[c].
  - Read requestor eligible: req_r_i[c] & ~w_fifo_prog_full_i[c].
- Arbitration:
  - In IDLE only, grant the first eligible k searching from last_grant+1 modulo 2*NUM_CH.
  - On grant, register cur_ch, cur_dir and last_grant=k; clear count.
  - No eligible requestor: remain in IDLE.
- States (registered). Decoded outputs are combinational from state and listed as we/stb/m_rdy/dat_o_enable:
  - IDLE 0/0/0/0. Grant -> WR_ISSUE if dir=0, RD_ISSUE if dir=1.
  - WR_ISSUE 1/1/0/1. Always -> WR_REQ (one cycle).
  - RD_ISSUE 0/1/0/1. Always -> RD_REQ (one cycle).
  - WR_REQ 1/1/0/0.
    - abort_i -> IDLE. abort_i takes priority over ack_i.
    - ack_i and read-FIFO empty -> WAIT.
    - ack_i otherwise -> WR_BURST.
  - RD_REQ 0/1/0/0.
    - abort_i -> IDLE.
    - ack_i and prog_full -> WAIT.
    - ack_i otherwise -> RD_BURST.
  - WR_BURST 1/1/1/1.
    - ~ack_i or abort_i -> IDLE.
    - FIFO empty or count==MAX_BURST -> WAIT.
  - RD_BURST 0/1/0/0.
    - ~ack_i or abort_i -> IDLE.
    - prog_full or count==MAX_BURST -> WAIT.
  - WAIT 0/0/0/0. ~ack_i -> IDLE.
- dat_o:
  - In WR_BURST: r_fifo_dat_i slice of cur_ch.
  - Otherwise: header {zero-extend, cur_dir, cur_ch}, with cur_ch in bits [CH_W-1:0] and cur_dir in bit CH_W.
- r_fifo_rd_o[cur_ch] (combinational): asserted = (state in WR_REQ or WR_BURST) & ack_i & ~abort_i & ~r_fifo_empty_i[cur_ch] & count<MAX_BURST.
  - All other bits 0.
  - Each pop increments count.
  - Pop in WR_REQ presents the first word in the same cycle the state moves to WR_BURST (FWFT FIFO).
- Write-FIFO path:
  - Each cycle: w_fifo_dat_o <= dat_i.
  - w_fifo_dat_valid_o[c] <= (state==RD_BURST) & s_rdy_i & ack_i & (c==cur_ch) & count<MAX_BURST.
  - Latency: dat_i to w_fifo_dat_o is 1 cycle.
  - Each push increments count.
- Counter:
  - Saturates at MAX_BURST. Never wraps.
  - Cleared only on grant.
- Simultaneous ack_i=0 and burst-cap in the same cycle: go to IDLE, not WAIT.

Decomposition:
- Package bus_master_pkg holds:
  - state_t enum: IDLE, WR_ISSUE, WR_REQ, WR_BURST, RD_ISSUE, RD_REQ, RD_BURST, WAIT.
  - Header field positions.
  - DIR_WR/DIR_RD constants.
- One sub-module: rr_arbiter.
  - Parameter N=2*NUM_CH.
  - Inputs: eligible vector, last_grant, enable.
  - Outputs: grant_valid, grant_idx.
  - Purely combinational; last_grant register stays in the parent.

Test Plan:
- Reset mid-WR_BURST (NUM_CH=2, ch1 streaming) -> stb_o=0 and r_fifo_rd_o=0 in the same cycle; after release, first grant goes to k=0 if eligible.
- All four requestors continuously eligible, ack_i held 4 cycles per transaction -> grant order k=0,1,2,3,0 (ch0W, ch0R, ch1W, ch1R, ch0W).
- MAX_BURST=4, ch0 read-FIFO holding 10 words, ack_i held high -> exactly 4 pops, dat_o carries words 0..3, then WAIT; after ack_i drop, IDLE; next ch0 write grant resumes at word 4.
- Read burst on ch1 with s_rdy_i pulsing, dat_i=0xA5A50001.. -> w_fifo_dat_valid_o=2'b10 one cycle after each s_rdy_i, data matching; w_fifo_dat_valid_o[0] stays 0 throughout.
- abort_i=1 in RD_REQ and again in WR_BURST -> IDLE next cycle; no further pops or pushes.
- Header check: ch1 read grant with NUM_CH=4 -> dat_o=0x00000005 during RD_ISSUE with dat_o_enable_o=1.
